// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and byte-lane merge helper for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LANES           = 4;
    localparam int unsigned LANE_W          = 8;
    localparam int unsigned WORD_W          = LANES * LANE_W;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_2000;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // New bytes on strobed lanes, old bytes elsewhere.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  strb
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int k = 0; k < int'(LANES); k++) begin
            if (strb[k]) begin
                res[k*LANE_W +: LANE_W] = new_w[k*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage with per-lane write enables and registered, write-first read.
// Optional per-byte even parity under DMEM_PARITY_EN.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr_i,
    input  logic [LANES-1:0]  we_i,
    input  logic [WORD_W-1:0] wd_i,
    input  logic              rd_en_i,
    input  logic              byp_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              par_err_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_d, rd_q;

    always_comb begin
        rd_d = '0;
        if (rd_en_i) begin
            rd_d = byp_i ? lane_merge(mem[addr_i], wd_i, we_i) : mem[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            if (we_i[k]) begin
                mem[addr_i][k*LANE_W +: LANE_W] <= wd_i[k*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_data_o = rd_q;

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par [DEPTH_WORDS];
    logic             par_err_d, par_err_q;
    logic             par_mis_c;

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            if (we_i[k]) begin
                par[addr_i][k] <= ^wd_i[k*LANE_W +: LANE_W];
            end
        end
    end

    // Check the stored word as it was before any same-cycle write.
    always_comb begin
        par_mis_c = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            if ((^mem[addr_i][k*LANE_W +: LANE_W]) != par[addr_i][k]) begin
                par_mis_c = 1'b1;
            end
        end
        par_err_d = par_err_q | (rd_en_i & par_mis_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: clear sweep, decode, error flag, write count.
// Optional parity checking is enabled by defining DMEM_PARITY_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      addr_i,
    input  logic [3:0]       wr_strb_i,
    input  logic [7:0]       wr_byte0_i,
    input  logic [7:0]       wr_byte1_i,
    input  logic [7:0]       wr_byte2_i,
    input  logic [7:0]       wr_byte3_i,
    output logic [31:0]      rd_data_o,
    output logic             init_busy_o,
    output logic             err_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic             par_err_o
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [0:0]       state_d, state_q;
    logic [AW-1:0]    sweep_d, sweep_q;
    logic             busy_d, busy_q;
    logic             err_d, err_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    logic [31:0]       off_c;
    logic              in_range_c;
    logic [AW-1:0]     idx_c;
    logic [WORD_W-1:0] wdata_c;
    logic [AW-1:0]     bank_addr_c;
    logic [LANES-1:0]  bank_we_c;
    logic [WORD_W-1:0] bank_wd_c;
    logic              rd_en_c;
    logic              byp_c;

    // Unsigned offset: addresses below base wrap high and fall out of range.
    assign off_c      = addr_i - BASE_ADDR;
    assign in_range_c = off_c < SPAN;
    assign idx_c      = off_c[AW+1:2];
    assign wdata_c    = {wr_byte3_i, wr_byte2_i, wr_byte1_i, wr_byte0_i};

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        busy_d      = busy_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        bank_addr_c = idx_c;
        bank_we_c   = '0;
        bank_wd_c   = wdata_c;
        rd_en_c     = 1'b0;
        byp_c       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                bank_addr_c = sweep_q;
                bank_we_c   = '1;
                bank_wd_c   = '0;
                if (sweep_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_READY: begin
                rd_en_c = in_range_c;
                if (|wr_strb_i && in_range_c) begin
                    bank_we_c = wr_strb_i;
                    byp_c     = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
                if (|wr_strb_i && !in_range_c) begin
                    err_d = 1'b1;
                end else if (err_clr_i) begin
                    err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (rstn) begin
            bank_we_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk      (clk),
        .rst      (rstn),
        .addr_i   (bank_addr_c),
        .we_i     (bank_we_c),
        .wd_i     (bank_wd_c),
        .rd_en_i  (rd_en_c),
        .byp_i    (byp_c),
        .rd_data_o(rd_data_o),
        .par_err_o(par_err_o)
    );

    assign init_busy_o = busy_q;
    assign err_o       = err_q;
    assign wr_cnt_o    = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; exercises the parity path when DMEM_PARITY_EN is defined.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr_i;
    logic [3:0]  wr_strb_i;
    logic [7:0]  wr_byte0_i, wr_byte1_i, wr_byte2_i, wr_byte3_i;
    logic [31:0] rd_data_o;
    logic        init_busy_o;
    logic        err_o;
    logic        err_clr_i;
    logic [15:0] wr_cnt_o;
    logic        par_err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic        m_err;
    logic [15:0] m_cnt;
    logic        m_par;
    logic [31:0] q_rd [$];
    logic [31:0] q_err [$];
    logic [31:0] q_cnt [$];

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .addr_i     (addr_i),
        .wr_strb_i  (wr_strb_i),
        .wr_byte0_i (wr_byte0_i),
        .wr_byte1_i (wr_byte1_i),
        .wr_byte2_i (wr_byte2_i),
        .wr_byte3_i (wr_byte3_i),
        .rd_data_o  (rd_data_o),
        .init_busy_o(init_busy_o),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i),
        .wr_cnt_o   (wr_cnt_o),
        .par_err_o  (par_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        m_err = 1'b0;
        m_cnt = 16'h0;
        m_par = 1'b0;
    endtask

    // One bus cycle: drive at a falling edge, predict, then check at the next falling edge.
    task automatic cyc(input string tag, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic clr);
        logic [31:0] off;
        logic        inr;
        int          ix;
        addr_i     = a;
        wr_strb_i  = s;
        wr_byte0_i = d[7:0];
        wr_byte1_i = d[15:8];
        wr_byte2_i = d[23:16];
        wr_byte3_i = d[31:24];
        err_clr_i  = clr;
        off = a - BASE;
        inr = (off < SPAN);
        ix  = int'(off >> 2) % int'(DEPTH);
        if (s != 4'h0 && inr) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) model[ix][k*8 +: 8] = d[k*8 +: 8];
            m_cnt = m_cnt + 16'h1;
        end
        if (s != 4'h0 && !inr) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        q_rd.push_back(inr ? model[ix] : 32'h0);
        q_err.push_back({31'h0, m_err});
        q_cnt.push_back({16'h0, m_cnt});
        @(negedge clk);
        chk({tag, "_rd"}, rd_data_o, q_rd.pop_front());
        chk({tag, "_err"}, {31'h0, err_o}, q_err.pop_front());
        chk({tag, "_cnt"}, {16'h0, wr_cnt_o}, q_cnt.pop_front());
        chk({tag, "_par"}, {31'h0, par_err_o}, {31'h0, m_par});
        wr_strb_i = 4'h0;
        err_clr_i = 1'b0;
    endtask

    task automatic do_reset();
        wr_strb_i = 4'h0;
        err_clr_i = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_busy_o === 1'b1 && n < int'(DEPTH) + 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(n), 32'(DEPTH));
        model_clear();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        addr_i = 32'h0;
        wr_strb_i = 4'h0;
        {wr_byte3_i, wr_byte2_i, wr_byte1_i, wr_byte0_i} = 32'h0;
        err_clr_i = 1'b0;
        model_clear();

        do_reset();
        chk("rst_rd", rd_data_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        chk("rst_cnt", {16'h0, wr_cnt_o}, 32'h0);
        chk("rst_busy", {31'h0, init_busy_o}, 32'h1);
        chk("rst_par", {31'h0, par_err_o}, 32'h0);
        wait_init("init");

        cyc("rd0", 32'h2000, 4'h0, 32'h0, 1'b0);
        cyc("rdtop", 32'h2FFC, 4'h0, 32'h0, 1'b0);
        cyc("rd4", 32'h2004, 4'h0, 32'h0, 1'b0);

        cyc("wfull", 32'h2004, 4'hF, 32'hDEADBEEF, 1'b0);
        cyc("rfull", 32'h2004, 4'h0, 32'h0, 1'b0);
        chk("rfull_const", rd_data_o, 32'hDEADBEEF);
        cyc("wb1", 32'h2004, 4'h2, 32'h0000_1200, 1'b0);
        cyc("rb1", 32'h2004, 4'h0, 32'h0, 1'b0);
        chk("rb1_const", rd_data_o, 32'hDEAD12EF);
        chk("cnt2", {16'h0, wr_cnt_o}, 32'd2);

        cyc("coll", 32'h2004, 4'h8, 32'hAA00_0000, 1'b0);
        chk("coll_const", rd_data_o, 32'hAAAD12EF);

        cyc("bad_lo", 32'h1FFC, 4'hF, 32'h1111_1111, 1'b0);
        chk("bad_lo_err", {31'h0, err_o}, 32'h1);
        cyc("bad_hi", BASE + SPAN, 4'hF, 32'h2222_2222, 1'b0);
        cyc("rd_lo", 32'h1FFC, 4'h0, 32'h0, 1'b0);
        cyc("rd_hi", BASE + SPAN, 4'h0, 32'h0, 1'b0);
        cyc("rd_last", 32'h2FFC, 4'h0, 32'h0, 1'b0);
        cyc("rd_first", 32'h2000, 4'h0, 32'h0, 1'b0);
        cyc("clr", 32'h2004, 4'h0, 32'h0, 1'b1);
        chk("clr_err", {31'h0, err_o}, 32'h0);
        cyc("clr_set", 32'h3000, 4'h1, 32'h33, 1'b1);
        chk("clr_set_err", {31'h0, err_o}, 32'h1);
        cyc("clr2", 32'h2004, 4'h0, 32'h0, 1'b1);

        cyc("odd", 32'h2010, 4'h5, 32'h1122_3344, 1'b0);
        cyc("odd_rd", 32'h2010, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cyc("rnd", 32'h1FF0 + 32'($urandom_range(0, 4120)), 4'($urandom_range(0, 15)),
                $urandom, ($urandom_range(0, 9) == 0));
        end

        do_reset();
        repeat (500) @(negedge clk);
        chk("mid_busy", {31'h0, init_busy_o}, 32'h1);
        do_reset();
        wait_init("restart");
        cyc("post_rst", 32'h2004, 4'h0, 32'h0, 1'b0);

        addr_i = 32'h2008;
        wr_strb_i = 4'h1;
        wr_byte0_i = 8'h5A;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        wr_strb_i = 4'h0;
        model[2][7:0] = 8'h5A;
        m_cnt = 16'hFFFF;
        chk("cnt_max", {16'h0, wr_cnt_o}, 32'h0000_FFFF);
        cyc("wrap", 32'h2008, 4'h2, 32'h0000_A500, 1'b0);
        chk("cnt_wrap", {16'h0, wr_cnt_o}, 32'h0);

`ifdef DMEM_PARITY_EN
        dut.u_bank.mem[1] = dut.u_bank.mem[1] ^ 32'h0000_0001;
        model[1] = model[1] ^ 32'h0000_0001;
        cyc("pre_par", 32'h2000, 4'h0, 32'h0, 1'b0);
        m_par = 1'b1;
        cyc("par_hit", 32'h2004, 4'h0, 32'h0, 1'b0);
        cyc("par_stick", 32'h2000, 4'h0, 32'h0, 1'b0);
        chk("par_const", {31'h0, par_err_o}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
